popcount21_unary_gen: RTL and testbench

- Inverse of the 21-input popcount cores: accepts a count 0..21 and serially emits a 21-bit frame containing exactly that many ones, then presents the assembled vector.
- Produces exact-weight stimulus for exercising and characterising the approximate popcount21 circuits.
- Also serves as a pulse-density encoder for printed-neuron test harnesses.

---
 rtl/popcount21_unary_gen_pkg.sv | 27 ++
 rtl/popcount21_unary_gen_if.sv | 24 ++
 rtl/popcount21_unary_gen_lfsr.sv | 27 ++
 rtl/popcount21_unary_gen.sv | 130 +++++++++++++
 tb/tb_popcount21_unary_gen.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount21_unary_gen_pkg.sv
// Shared constants, state type and helpers for the popcount21 unary generator.
// Also used by the testbench reference model (popcnt21).
package popcount_pkg;

  localparam int unsigned N_IN  = 21;
  localparam int unsigned CNT_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } gen_state_t;

  // Clamp a requested count to the frame length.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(N_IN)) ? CNT_W'(N_IN) : c;
  endfunction

  function automatic int unsigned popcnt21(input logic [N_IN-1:0] v);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      s += {31'd0, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/popcount21_unary_gen_if.sv
// Request / serial-frame / vector bus of the popcount21 unary generator.
interface popcount21_unary_gen_if;
  import popcount_pkg::*;

  logic [CNT_W-1:0] in_count;
  logic             in_valid;
  logic             in_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_last;
  logic [N_IN-1:0]  vec_out;
  logic             vec_valid;
  logic             busy;

  modport master (
    output in_count, in_valid,
    input  in_ready, bit_out, bit_valid, bit_last, vec_out, vec_valid, busy
  );

  modport slave (
    input  in_count, in_valid,
    output in_ready, bit_out, bit_valid, bit_last, vec_out, vec_valid, busy
  );
endinterface

// File: rtl/popcount21_unary_gen_lfsr.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, advancing only while en is high.
module lfsr16_galois #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/popcount21_unary_gen.sv
// Count-to-frame generator: emits an N_IN-bit frame with exactly min(count,N_IN) ones.
// Define POPCOUNT_UNARY_RAND_EN for LFSR selection-sampling placement; default is thermometer.
module popcount21_unary_gen
  import popcount_pkg::*;
#(
  parameter int unsigned N_IN  = 21,
  parameter int unsigned CNT_W = 5,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input logic                 clk,
  input logic                 rst_n,
  popcount21_unary_gen_if.slave bus
);

  if (N_IN != popcount_pkg::N_IN || CNT_W != popcount_pkg::CNT_W || SEED == 16'h0000) begin : g_bad_cfg
    $error("popcount21_unary_gen: unsupported parameter set");
  end

  gen_state_t        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [N_IN-1:0]   sr_q, sr_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              vec_valid_q, vec_valid_d;

  logic emitting;
  logic last_cyc;
  logic ready;
  logic accept;
  logic b;

  assign emitting = (state_q == EMIT);
  assign last_cyc = emitting && (idx_q == CNT_W'(N_IN - 1));
  assign ready    = (state_q == IDLE) || last_cyc;
  assign accept   = bus.in_valid && ready;

`ifdef POPCOUNT_UNARY_RAND_EN
  logic [15:0]      lfsr_state;
  logic [CNT_W-1:0] n;
  logic [12:0]      prod;
  logic             unused_lfsr_hi;

  lfsr16_galois #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (emitting),
    .state (lfsr_state)
  );

  assign n              = CNT_W'(N_IN) - idx_q;
  assign prod           = 13'(lfsr_state[7:0]) * 13'(n);
  assign unused_lfsr_hi = ^lfsr_state[15:8];

  // Selection sampling: keep a bit with probability rem/n; edge cases force exactness.
  always_comb begin
    b = 1'b0;
    if (emitting) begin
      if (rem_q == '0)      b = 1'b0;
      else if (rem_q >= n)  b = 1'b1;
      else                  b = (prod[12:8] < rem_q);
    end
  end
`else
  always_comb begin
    b = emitting && (rem_q != '0);
  end
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    sr_d        = sr_q;
    vec_d       = vec_q;
    vec_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EMIT;
          idx_d   = '0;
          rem_d   = sat_count(bus.in_count);
        end
      end
      EMIT: begin
        // Shift in from the top so frame bit i lands in position i after N_IN cycles.
        sr_d  = {b, sr_q[N_IN-1:1]};
        idx_d = idx_q + CNT_W'(1);
        if (b) rem_d = rem_q - CNT_W'(1);
        if (last_cyc) begin
          vec_d       = {b, sr_q[N_IN-1:1]};
          vec_valid_d = 1'b1;
          idx_d       = '0;
          if (accept) begin
            rem_d = sat_count(bus.in_count);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      sr_q        <= '0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      sr_q        <= sr_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.bit_out   = b;
  assign bus.bit_valid = emitting;
  assign bus.bit_last  = last_cyc;
  assign bus.busy      = emitting;
  assign bus.vec_out   = vec_q;
  assign bus.vec_valid = vec_valid_q;

endmodule

// File: tb/tb_popcount21_unary_gen.sv
// Scoreboard bench for popcount21_unary_gen: random counts against a count-level model.
module tb_popcount21_unary_gen;
  import popcount_pkg::*;

  logic clk;
  logic rst_n;

  popcount21_unary_gen_if bus ();

  popcount21_unary_gen #(.N_IN(21), .CNT_W(5), .SEED(16'hACE1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          cnt;
    logic [20:0] ser;
  } vexp_t;

  int    cq[$];
  vexp_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c);
    return (c > 21) ? 21 : c;
  endfunction

  function automatic logic [20:0] therm(input int c);
    logic [20:0] v;
    v = '0;
    for (int i = 0; i < c; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: frame model built from the accepted counts only.
  int          fidx = 0;
  int          cur_cnt = 0;
  int          ones = 0;
  logic [20:0] acc = '0;
  logic        prev_last = 1'b0;
  logic [20:0] held = '0;
  int          n10 = 0;
  logic [20:0] first10 = '0;
  bit          diff10 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
      chk("rst_bit_out", 32'(bus.bit_out), 32'd0);
      chk("rst_bit_last", 32'(bus.bit_last), 32'd0);
      chk("rst_vec_out", 32'(bus.vec_out), 32'd0);
      chk("rst_vec_valid", 32'(bus.vec_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      fidx = 0; ones = 0; acc = '0; prev_last = 1'b0; held = '0;
      cq.delete(); vq.delete();
    end else begin
      vexp_t e;
      logic  exp_b;
      bit    last_now;
      int    rem, n;
      chk("vec_valid_timing", 32'(bus.vec_valid), 32'(prev_last));
      if (bus.vec_valid) begin
        if (vq.size() == 0) begin
          chk("vec_unexpected", 32'(bus.vec_valid), 32'd0);
        end else begin
          e = vq.pop_front();
          chk("vec_popcount", popcnt21(bus.vec_out), 32'(e.cnt));
`ifdef POPCOUNT_UNARY_RAND_EN
          chk("vec_vs_serial", 32'(bus.vec_out), 32'(e.ser));
          held = e.ser;
          if (e.cnt == 10) begin
            if (n10 > 0 && bus.vec_out != first10) diff10 = 1'b1;
            if (n10 == 0) first10 = bus.vec_out;
            n10++;
          end
`else
          chk("vec_out", 32'(bus.vec_out), 32'(therm(e.cnt)));
          held = therm(e.cnt);
`endif
        end
      end else begin
        chk("vec_hold", 32'(bus.vec_out), 32'(held));
      end
      if (fidx > 0) chk("frame_continuous", 32'(bus.bit_valid), 32'd1);
      chk("busy_eq_bit_valid", 32'(bus.busy), 32'(bus.bit_valid));
      last_now = 1'b0;
      if (bus.bit_valid) begin
        if (fidx == 0) begin
          if (cq.size() == 0) begin
            chk("frame_unexpected", 32'(bus.bit_valid), 32'd0);
            cur_cnt = 0;
          end else begin
            cur_cnt = cq.pop_front();
          end
          ones = 0;
          acc  = '0;
        end
        rem = cur_cnt - ones;
        n   = 21 - fidx;
`ifdef POPCOUNT_UNARY_RAND_EN
        if (rem == 0)       chk("bit_rem0", 32'(bus.bit_out), 32'd0);
        else if (rem >= n)  chk("bit_rem_n", 32'(bus.bit_out), 32'd1);
        exp_b = bus.bit_out;
`else
        exp_b = (fidx < cur_cnt);
        chk("bit_out", 32'(bus.bit_out), 32'(exp_b));
`endif
        acc[fidx] = exp_b;
        ones += (exp_b ? 1 : 0);
        last_now = (fidx == 20);
        chk("bit_last", 32'(bus.bit_last), 32'(last_now));
        chk("in_ready_emit", 32'(bus.in_ready), 32'(last_now));
        if (last_now) begin
          vq.push_back('{cnt: cur_cnt, ser: acc});
          fidx = 0;
        end else begin
          fidx++;
        end
      end else begin
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      end
      prev_last = last_now;
    end
  end

  // Issue one request and hold it until accepted; returns at the negedge of frame cycle 0.
  task automatic send(input int c);
    bit done;
    done = 1'b0;
    bus.in_count = 5'(c);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (bus.in_ready) begin
        cq.push_back(sat(c));
        @(posedge clk);
        @(negedge clk);
        chk("first_bit_latency", 32'(bus.bit_valid), 32'd1);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (!bus.busy && cq.size() == 0 && vq.size() == 0) done = 1'b1;
    end
    chk("drain", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_count = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    send(5);
    wait_idle();
    send(0);
    send(21);
    wait_idle();
    send(25);
    wait_idle();

    // Request held through frame cycles 0..19 must not be taken until cycle 20.
    send(7);
    bus.in_count = 5'd9;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("ready_low_mid_frame", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    chk("ready_at_cycle20", 32'(bus.in_ready), 32'd1);
    send(9);
    wait_idle();

    // Reset pulsed at frame cycle 9 of a count=12 frame.
    send(12);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("async_rst_bit_valid", 32'(bus.bit_valid), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_vec_valid", 32'(bus.vec_valid), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(3);
    wait_idle();

    for (int i = 0; i < 2000; i++) begin
      send($urandom_range(0, 21));
    end
    wait_idle();

`ifdef POPCOUNT_UNARY_RAND_EN
    if (n10 >= 2) chk("count10_vectors_differ", 32'(diff10), 32'd1);
`endif
    chk("queues_empty", 32'(cq.size() + vq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
